// File: rtl/spi_cmd_handler.sv
// Command decoder behind the SPI slave. It executes register writes and schedules
// 1/2/6-byte replies. It also arms and captures 6-byte long-write frames.
module spi_cmd_handler #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd1000000,
    parameter logic [3:0]  LONG_BYTES  = 4'd6
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        received,
    input  logic        busy,
    input  logic [15:0] received_data,
    input  logic [47:0] long_dataIN,
    input  logic [15:0] status_in,
    input  logic [47:0] wide_in,
    output logic        send_trigger,
    output logic [47:0] output_data,
    output logic [2:0]  SPI_MSG_TYPE,
    output logic        LongMsgComing,
    output logic [3:0]  InMsgByteCount,
    output logic [63:0] ctrl_regs,
    output logic [47:0] long_out,
    output logic        long_valid,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {IDLE, REPLY_REQ, REPLY_WAIT, LONG_ARM, LONG_RX} state_t;

    state_t      state, state_nx;
    logic        trig_nx, lmc_nx, lv_nx, err_inc;
    logic [47:0] out_nx, long_nx;
    logic [2:0]  type_nx;
    logic [63:0] regs_nx;
    logic [23:0] cnt, cnt_nx;

    logic [3:0]  op;
    logic [5:0]  bit_base;
    logic [7:0]  data;
    logic        unused_bit11;

    assign op             = received_data[15:12];
    assign bit_base       = {received_data[10:8], 3'b000};
    assign data           = received_data[7:0];
    assign unused_bit11   = received_data[11];
    assign InMsgByteCount = LONG_BYTES;

    always_comb begin
        state_nx = state;
        trig_nx  = send_trigger;
        out_nx   = output_data;
        type_nx  = SPI_MSG_TYPE;
        lmc_nx   = LongMsgComing;
        regs_nx  = ctrl_regs;
        long_nx  = long_out;
        lv_nx    = 1'b0;
        cnt_nx   = cnt;
        err_inc  = 1'b0;
        case (state)
            IDLE: if (received) begin
                case (op)
                    4'd1: regs_nx[bit_base +: 8] = data;
                    4'd2: begin
                        out_nx   = {40'b0, ctrl_regs[bit_base +: 8]};
                        type_nx  = 3'b001;
                        trig_nx  = 1'b1;
                        state_nx = REPLY_REQ;
                    end
                    4'd3: begin
                        out_nx   = {32'b0, status_in};
                        type_nx  = 3'b010;
                        trig_nx  = 1'b1;
                        state_nx = REPLY_REQ;
                    end
                    4'd4: begin
                        out_nx   = wide_in;
                        type_nx  = 3'b110;
                        trig_nx  = 1'b1;
                        state_nx = REPLY_REQ;
                    end
                    4'd5: begin
                        lmc_nx   = 1'b1;
                        cnt_nx   = '0;
                        state_nx = LONG_ARM;
                    end
                    default: err_inc = 1'b1;
                endcase
            end
            REPLY_REQ: begin
                if (received) err_inc = 1'b1;
                if (busy) begin
                    trig_nx  = 1'b0;
                    state_nx = REPLY_WAIT;
                end
            end
            // Slave may still show busy for a cycle after finishing; wait it out.
            REPLY_WAIT: begin
                if (received) err_inc = 1'b1;
                if (!busy) state_nx = IDLE;
            end
            LONG_ARM: begin
                if (received) err_inc = 1'b1;
                if (busy) begin
                    state_nx = LONG_RX;
                end else if (cnt == TIMEOUT_CYC - 24'd1) begin
                    lmc_nx   = 1'b0;
                    err_inc  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 24'd1;
                end
            end
            LONG_RX: if (received) begin
                long_nx  = long_dataIN;
                lv_nx    = 1'b1;
                lmc_nx   = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            send_trigger  <= 1'b0;
            output_data   <= '0;
            SPI_MSG_TYPE  <= 3'b010;
            LongMsgComing <= 1'b0;
            ctrl_regs     <= '0;
            long_out      <= '0;
            long_valid    <= 1'b0;
            err_cnt       <= '0;
            cnt           <= '0;
        end else begin
            state         <= state_nx;
            send_trigger  <= trig_nx;
            output_data   <= out_nx;
            SPI_MSG_TYPE  <= type_nx;
            LongMsgComing <= lmc_nx;
            ctrl_regs     <= regs_nx;
            long_out      <= long_nx;
            long_valid    <= lv_nx;
            cnt           <= cnt_nx;
            if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_spi_cmd_handler.sv
// Scoreboarded random bench for spi_cmd_handler. A high-level model predicts
// replies, registers and errors, and a negedge monitor checks DUT outputs.
module tb_spi_cmd_handler;
    localparam logic [23:0] TO = 24'd16;

    logic CLK = 1'b0;
    logic RST, received, busy;
    logic [15:0] received_data, status_in;
    logic [47:0] long_dataIN, wide_in;
    logic        send_trigger, LongMsgComing, long_valid;
    logic [47:0] output_data, long_out;
    logic [2:0]  SPI_MSG_TYPE;
    logic [3:0]  InMsgByteCount;
    logic [63:0] ctrl_regs;
    logic [7:0]  err_cnt;

    spi_cmd_handler #(.TIMEOUT_CYC(TO), .LONG_BYTES(4'd6)) dut (
        .CLK(CLK), .RST(RST), .received(received), .busy(busy),
        .received_data(received_data), .long_dataIN(long_dataIN),
        .status_in(status_in), .wide_in(wide_in), .send_trigger(send_trigger),
        .output_data(output_data), .SPI_MSG_TYPE(SPI_MSG_TYPE),
        .LongMsgComing(LongMsgComing), .InMsgByteCount(InMsgByteCount),
        .ctrl_regs(ctrl_regs), .long_out(long_out), .long_valid(long_valid),
        .err_cnt(err_cnt)
    );

    always #5 CLK = ~CLK;

    int errors = 0, checks = 0;
    logic [7:0]  m_regs [8];
    int          m_err;
    logic [50:0] rq [$];
    logic [47:0] lq [$];
    logic [47:0] exp_last;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] m_flat();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = m_regs[i];
        return r;
    endfunction

    function automatic void bump();
        if (m_err < 255) m_err++;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_err = 0;
    endfunction

    // Monitor: compare each reply as send_trigger rises and each long capture.
    logic prev_trig = 1'b0, prev_lv = 1'b0;
    always @(negedge CLK) begin
        logic [50:0] e;
        if (send_trigger && !prev_trig) begin
            if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_reply: got %h expected none", output_data);
            end else begin
                e = rq.pop_front();
                chk("reply_type", 64'(SPI_MSG_TYPE), 64'(e[50:48]));
                chk("reply_data", 64'(output_data), 64'(e[47:0]));
            end
        end
        if (long_valid) begin
            chk("long_valid_width", 64'(prev_lv), 64'd0);
            if (lq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_long: got %h expected none", long_out);
            end else chk("long_out", 64'(long_out), 64'(lq.pop_front()));
        end
        prev_trig <= send_trigger;
        prev_lv   <= long_valid;
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic send(input logic [15:0] cmd);
        int a;
        a = int'(cmd[10:8]);
        case (cmd[15:12])
            4'd1: m_regs[a] = cmd[7:0];
            4'd2: begin exp_last = {40'b0, m_regs[a]};   rq.push_back({3'b001, exp_last}); end
            4'd3: begin exp_last = {32'b0, status_in};   rq.push_back({3'b010, exp_last}); end
            4'd4: begin exp_last = wide_in;              rq.push_back({3'b110, exp_last}); end
            4'd5: ;
            default: bump();
        endcase
        received_data = cmd;
        received = 1'b1;
        tick();
        received = 1'b0;
    endtask

    task automatic serve_reply(input bit stray);
        int n;
        n = 0;
        while (!send_trigger && n < 10) begin tick(); n++; end
        chk("trigger_latency", 64'(n), 64'd0);
        status_in = 16'($urandom);
        wide_in   = {16'($urandom), 32'($urandom)};
        repeat ($urandom_range(0, 2)) tick();
        chk("trigger_before_busy", 64'(send_trigger), 64'd1);
        busy = 1'b1;
        tick();
        chk("trigger_drop", 64'(send_trigger), 64'd0);
        chk("reply_frozen", 64'(output_data), 64'(exp_last));
        if (stray) begin
            received_data = {4'h1, 1'b0, 3'($urandom), 8'($urandom)};
            received = 1'b1;
            bump();
            tick();
            received = 1'b0;
        end
        repeat (2) tick();
        busy = 1'b0;
        tick();
    endtask

    task automatic long_frame(input logic [47:0] payload);
        chk("lmc_armed", 64'(LongMsgComing), 64'd1);
        repeat ($urandom_range(0, 5)) tick();
        busy = 1'b1;
        tick(); tick();
        chk("lmc_before_frame", 64'(LongMsgComing), 64'd1);
        long_dataIN = payload;
        lq.push_back(payload);
        received = 1'b1;
        tick();
        received = 1'b0;
        chk("lmc_after_long", 64'(LongMsgComing), 64'd0);
        busy = 1'b0;
        tick();
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_regs"}, ctrl_regs, m_flat());
        chk({tag, "_err"}, 64'(err_cnt), 64'(m_err));
    endtask

    task automatic check_reset_vals();
        chk("rst_trigger", 64'(send_trigger), 64'd0);
        chk("rst_outdata", 64'(output_data), 64'd0);
        chk("rst_type", 64'(SPI_MSG_TYPE), 64'd2);
        chk("rst_lmc", 64'(LongMsgComing), 64'd0);
        chk("rst_bytecount", 64'(InMsgByteCount), 64'd6);
        chk("rst_long_out", 64'(long_out), 64'd0);
        chk("rst_long_valid", 64'(long_valid), 64'd0);
        check_state("rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] c;
        int n;
        RST = 1'b1; received = 1'b0; busy = 1'b0; received_data = '0;
        long_dataIN = '0; status_in = '0; wide_in = '0;
        model_reset();
        repeat (3) tick();
        check_reset_vals();
        RST = 1'b0;
        tick();

        send(16'h1355);
        chk("write_reg3", 64'(ctrl_regs[31:24]), 64'h55);
        chk("write_no_trigger", 64'(send_trigger), 64'd0);
        check_state("write");
        send(16'h2300); serve_reply(1'b0);
        status_in = 16'hBEEF;
        send(16'h3000); serve_reply(1'b0);
        send(16'h5000); long_frame(48'h0123456789AB);
        check_state("long");

        send(16'h5000);
        n = 0;
        while (LongMsgComing && n < 40) begin n++; tick(); end
        bump();
        chk("timeout_cycles", 64'(n), 64'd16);
        check_state("timeout");
        send(16'h1101);
        check_state("after_timeout");

        for (int i = 0; i < 60; i++) begin
            c = 16'($urandom);
            status_in = 16'($urandom);
            wide_in   = {16'($urandom), 32'($urandom)};
            send(c);
            if (c[15:12] inside {4'd2, 4'd3, 4'd4}) serve_reply(1'($urandom));
            else if (c[15:12] == 4'd5) long_frame({16'($urandom), 32'($urandom)});
            check_state("rand");
        end

        repeat (300) send({4'hF, 12'($urandom)});
        chk("err_saturate", 64'(err_cnt), 64'hFF);
        check_state("sat");

        send(16'h2300);
        chk("trigger_pre_reset", 64'(send_trigger), 64'd1);
        RST = 1'b1;
        model_reset();
        tick();
        check_reset_vals();
        RST = 1'b0;
        tick();
        send(16'h1742);
        send(16'h2700); serve_reply(1'b0);
        check_state("post_reset");

        chk("reply_queue_empty", 64'(rq.size()), 64'd0);
        chk("long_queue_empty", 64'(lq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
